crc32_checker: RTL and testbench

//  Receive-side companion to crc32: checks word-streamed frames whose final word is the CRC-32 the sender computed.

---
 rtl/crc32_checker.sv | 191 +++++++++++++++++++
 tb/tb_crc32_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_checker.sv
`default_nettype none
// ============================================================================
// Module   : crc32_checker
// Brief    : Checks word-streamed frames against a trailing CRC-32 word and
//            issues a one-cycle verdict. Also keeps saturating good/bad counters.
// Revision : 1.0
// ============================================================================
module crc32_checker #(
    parameter int          DATA_W    = 32,
    parameter logic [31:0] POLY      = 32'h04C11DB7,
    parameter logic [31:0] CRC_INIT  = 32'hFFFFFFFF,
    parameter int          MAX_WORDS = 1024,
    parameter int          LEN_W     = 16,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              clr_cnt,
    output logic              chk_valid,
    output logic              chk_ok,
    output logic [1:0]        chk_err,
    output logic [LEN_W-1:0]  frame_len,
    output logic [31:0]       crc_calc,
    output logic [31:0]       crc_rx,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  bad_cnt
);

    localparam int             OV_W        = $clog2(MAX_WORDS + 2);
    localparam logic [OV_W-1:0] c_MAX      = OV_W'(MAX_WORDS);
    localparam logic [1:0]     c_ERR_OK    = 2'd0;
    localparam logic [1:0]     c_ERR_CRC   = 2'd1;
    localparam logic [1:0]     c_ERR_RUNT  = 2'd2;
    localparam logic [1:0]     c_ERR_OVL   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DROP  = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_crc;
    logic [LEN_W-1:0]  r_len;
    logic [OV_W-1:0]   r_ovl_cnt;
    logic [1:0]        r_chk_err;
    logic [LEN_W-1:0]  r_frame_len;
    logic [31:0]       r_crc_calc;
    logic [31:0]       r_crc_rx;
    logic [CNT_W-1:0]  r_good_cnt;
    logic [CNT_W-1:0]  r_bad_cnt;
    logic              w_accept;
    logic [LEN_W-1:0]  w_len_inc;
    logic [31:0]       w_crc_step;
    logic              w_at_max;

    // 32 data bits folded in MSB-first per cycle, no reflection, no final XOR.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = (r << 1) ^ POLY;
            else              r = r << 1;
        end
        return r;
    endfunction

    assign s_ready    = (r_state != CHECK);
    assign w_accept   = s_valid && s_ready;
    assign w_len_inc  = (r_len == '1) ? r_len : r_len + LEN_W'(1);
    assign w_crc_step = crc_step(r_crc, s_data[31:0]);
    assign w_at_max   = (r_ovl_cnt == c_MAX);

    assign chk_valid  = (r_state == CHECK);
    assign chk_ok     = chk_valid && (r_chk_err == c_ERR_OK);
    assign chk_err    = r_chk_err;
    assign frame_len  = r_frame_len;
    assign crc_calc   = r_crc_calc;
    assign crc_rx     = r_crc_rx;
    assign good_cnt   = r_good_cnt;
    assign bad_cnt    = r_bad_cnt;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = s_last ? CHECK : DATA;
            end
            DATA: begin
                if (w_accept) begin
                    if (s_last)        w_state_next = CHECK;
                    else if (w_at_max) w_state_next = DROP;
                end
            end
            DROP: begin
                if (w_accept && s_last) w_state_next = CHECK;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Verdict fields are captured on the edge that accepts the CRC word,
    // so they are already valid while chk_valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc       <= CRC_INIT;
            r_len       <= '0;
            r_ovl_cnt   <= '0;
            r_chk_err   <= c_ERR_OK;
            r_frame_len <= '0;
            r_crc_calc  <= '0;
            r_crc_rx    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (s_last) begin
                            r_chk_err   <= c_ERR_RUNT;
                            r_frame_len <= '0;
                            r_crc_calc  <= r_crc;
                            r_crc_rx    <= s_data[31:0];
                        end else begin
                            r_crc     <= w_crc_step;
                            r_len     <= LEN_W'(1);
                            r_ovl_cnt <= OV_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        if (s_last) begin
                            r_chk_err   <= (s_data[31:0] != r_crc) ? c_ERR_CRC : c_ERR_OK;
                            r_frame_len <= r_len;
                            r_crc_calc  <= r_crc;
                            r_crc_rx    <= s_data[31:0];
                        end else if (w_at_max) begin
                            r_len <= w_len_inc;
                        end else begin
                            r_crc     <= w_crc_step;
                            r_len     <= w_len_inc;
                            r_ovl_cnt <= r_ovl_cnt + OV_W'(1);
                        end
                    end
                end
                DROP: begin
                    if (w_accept) begin
                        if (s_last) begin
                            r_chk_err   <= c_ERR_OVL;
                            r_frame_len <= r_len;
                            r_crc_calc  <= r_crc;
                            r_crc_rx    <= s_data[31:0];
                        end else begin
                            r_len <= w_len_inc;
                        end
                    end
                end
                default: begin
                    r_crc     <= CRC_INIT;
                    r_len     <= '0;
                    r_ovl_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (chk_valid) begin
            if (chk_ok) begin
                if (r_good_cnt != '1) r_good_cnt <= r_good_cnt + CNT_W'(1);
            end else begin
                if (r_bad_cnt != '1) r_bad_cnt <= r_bad_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc32_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc32_checker
// Brief    : Randomized scoreboard bench for crc32_checker (MAX_WORDS=4).
// Revision : 1.0
// ============================================================================
module tb_crc32_checker;

    localparam int          MAXW  = 4;
    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [31:0] INIT  = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        chk_valid, chk_ok;
    logic [1:0]  chk_err;
    logic [15:0] frame_len, good_cnt, bad_cnt;
    logic [31:0] crc_calc, crc_rx;

    crc32_checker #(
        .DATA_W(32), .POLY(POLY), .CRC_INIT(INIT),
        .MAX_WORDS(MAXW), .LEN_W(16), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .clr_cnt(clr_cnt),
        .chk_valid(chk_valid), .chk_ok(chk_ok), .chk_err(chk_err),
        .frame_len(frame_len), .crc_calc(crc_calc), .crc_rx(crc_rx),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ok;
        logic [1:0]  err;
        logic [15:0] len;
        logic [31:0] calc;
        logic [31:0] rx;
        logic        use_calc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] payload[$];
    int          checks = 0;
    int          passed = 0;
    int          pushed = 0;
    int          seen   = 0;
    int          mg = 0, mb = 0;
    bit          cnt_pending = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Remainder of (x * x^32) modulo the generator polynomial, by long division.
    function automatic logic [31:0] mod_step(input logic [31:0] x);
        logic [63:0] v;
        logic [63:0] g;
        v = {x, 32'h0};
        g = {31'h0, 1'b1, POLY};
        for (int b = 63; b >= 32; b--)
            if (v[b]) v = v ^ (g << (b - 32));
        return v[31:0];
    endfunction

    function automatic logic [31:0] crc_model(input int n);
        logic [31:0] c;
        c = INIT;
        for (int i = 0; i < n; i++) c = mod_step(c ^ payload[i]);
        return c;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last, input int maxgap);
        int gap;
        int t;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = d; s_last = last;
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 50) begin
            @(negedge clk); t++;
        end
        if (t >= 50) begin
            checks++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // mode: 0 correct CRC, 1 bit 0 flipped, 2 random single-bit flip
    task automatic send_frame(input int n, input int mode, input int maxgap, input bit clr);
        exp_t        e;
        logic [31:0] calc;
        logic [31:0] rx;
        calc = crc_model((n > MAXW) ? MAXW : n);
        case (mode)
            0:       rx = calc;
            1:       rx = calc ^ 32'h1;
            default: rx = calc ^ (32'h1 << $urandom_range(0, 31));
        endcase
        e.use_calc = 1'b1;
        if (n == 0) begin
            e.err = 2'd2;
        end else if (n > MAXW) begin
            e.err = 2'd3;
            e.use_calc = 1'b0;
        end else begin
            e.err = (rx != calc) ? 2'd1 : 2'd0;
        end
        e.ok   = (e.err == 2'd0);
        e.len  = 16'(n);
        e.calc = calc;
        e.rx   = rx;
        for (int i = 0; i < n; i++) send_word(payload[i], 1'b0, maxgap);
        exp_q.push_back(e);
        pushed++;
        send_word(rx, 1'b1, maxgap);
        if (clr) begin
            clr_cnt = 1'b1;
            @(posedge clk); #1;
            clr_cnt = 1'b0;
        end
    endtask

    task automatic fill_seq(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(32'(i + 1));
    endtask

    task automatic fill_rand(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back($urandom);
    endtask

    // Monitor: pops the scoreboard on each verdict and tracks expected counters.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mg = 0; mb = 0; cnt_pending = 0;
        end else begin
            if (cnt_pending) begin
                chk("good_cnt", 32'(good_cnt), 32'(mg));
                chk("bad_cnt", 32'(bad_cnt), 32'(mb));
                cnt_pending = 0;
            end
            if (chk_valid) begin
                seen++;
                chk("s_ready_in_check", 32'(s_ready), 32'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_verdict: got chk_valid=1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    chk("chk_ok", 32'(chk_ok), 32'(e.ok));
                    chk("chk_err", 32'(chk_err), 32'(e.err));
                    chk("frame_len", 32'(frame_len), 32'(e.len));
                    chk("crc_rx", crc_rx, e.rx);
                    if (e.use_calc) chk("crc_calc", crc_calc, e.calc);
                    if (clr_cnt) begin
                        mg = 0; mb = 0;
                    end else if (e.ok) mg++;
                    else mb++;
                    cnt_pending = 1;
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'h1);
        chk("rst_chk_valid", 32'(chk_valid), 32'h0);
        chk("rst_chk_ok", 32'(chk_ok), 32'h0);
        chk("rst_chk_err", 32'(chk_err), 32'h0);
        chk("rst_frame_len", 32'(frame_len), 32'h0);
        chk("rst_crc_calc", crc_calc, 32'h0);
        chk("rst_crc_rx", crc_rx, 32'h0);
        chk("rst_good_cnt", 32'(good_cnt), 32'h0);
        chk("rst_bad_cnt", 32'(bad_cnt), 32'h0);
        @(posedge clk); #1;

        // Directed: good, flipped bit 0, runt, boundary, overlength, gaps
        fill_seq(4); send_frame(4, 0, 0, 0);
        fill_seq(4); send_frame(4, 1, 0, 0);
        fill_seq(0); send_frame(0, 0, 0, 0);
        fill_seq(3); send_frame(3, 0, 0, 0);
        fill_seq(6); send_frame(6, 0, 0, 0);
        fill_seq(3); send_frame(3, 0, 3, 0);
        fill_seq(3); send_frame(3, 0, 3, 0);

        // Abort a frame with reset mid-way; no verdict may appear for it
        repeat (2) @(posedge clk); #1;
        fill_rand(6);
        for (int i = 0; i < 3; i++) send_word(payload[i], 1'b0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_abort_good_cnt", 32'(good_cnt), 32'h0);
        @(posedge clk); #1;
        fill_rand(3); send_frame(3, 0, 0, 0);
        fill_rand(2); send_frame(2, 0, 0, 1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            n = int'($urandom_range(0, 6));
            fill_rand(n);
            send_frame(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 0));
        end

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        chk("verdict_count", 32'(seen), 32'(pushed));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
